// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Access sizes, FSM states and the byte count of each access size.
package lsu_pkg;

    typedef enum logic [2:0] {
        SzD   = 3'd0,
        SzW   = 3'd1,
        SzH   = 3'd2,
        SzB   = 3'd3,
        SzWu  = 3'd4,
        SzHu  = 3'd5,
        SzBu  = 3'd6,
        SzBad = 3'd7
    } ls_size_t;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StWrite,
        StResp
    } lsu_state_t;

    // Illegal size reports 1 so it never adds an alignment constraint.
    function automatic logic [3:0] size_bytes(ls_size_t size);
        case (size)
            SzD:        size_bytes = 4'd8;
            SzW, SzWu:  size_bytes = 4'd4;
            SzH, SzHu:  size_bytes = 4'd2;
            default:    size_bytes = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: load extraction with extension,
// and store merge of sub-doubleword data into an old doubleword.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [63:0] old_i,
    input  logic [63:0] wdata_i,
    input  logic [2:0]  offset_i,
    input  logic [2:0]  size_i,
    output logic [63:0] load_o,
    output logic [63:0] merge_o
);

    ls_size_t    size;
    logic [63:0] rshift;
    logic [63:0] wshift;
    logic [3:0]  lane_lo;
    logic [3:0]  lane_hi;

    assign size    = ls_size_t'(size_i);
    assign rshift  = rdata_i >> {offset_i, 3'b000};
    assign wshift  = wdata_i << {offset_i, 3'b000};
    assign lane_lo = {1'b0, offset_i};
    assign lane_hi = lane_lo + size_bytes(size);

    always_comb begin
        case (size)
            SzW:     load_o = {{32{rshift[31]}}, rshift[31:0]};
            SzH:     load_o = {{48{rshift[15]}}, rshift[15:0]};
            SzB:     load_o = {{56{rshift[7]}}, rshift[7:0]};
            SzWu:    load_o = {32'd0, rshift[31:0]};
            SzHu:    load_o = {48'd0, rshift[15:0]};
            SzBu:    load_o = {56'd0, rshift[7:0]};
            default: load_o = rshift;
        endcase
    end

    // Lanes [offset, offset+size) take the shifted store data.
    always_comb begin
        merge_o = old_i;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) >= lane_lo && 4'(i) < lane_hi) begin
                merge_o[8*i +: 8] = wshift[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store engine between the datapath and a 64-bit data memory with
// registered read; sub-doubleword stores are read-modify-write, bad requests trap.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic              store_q, store_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    ls_size_t          req_size_e;
    logic [3:0]        req_nbytes;
    logic              req_bad;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    assign req_size_e = ls_size_t'(req_size);
    assign req_nbytes = size_bytes(req_size_e);
    assign req_bad    = (req_size_e == SzBad)
                     || (req_store && (req_size_e inside {SzWu, SzHu, SzBu}))
                     || ((req_addr[2:0] & 3'(req_nbytes - 4'd1)) != 3'd0);

    lsu_align u_align (
        .rdata_i  (mem_rdata),
        .old_i    (old_q),
        .wdata_i  (wdata_q),
        .offset_i (addr_q[2:0]),
        .size_i   (size_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        store_d = store_q;
        err_d   = err_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    store_d = req_store;
                    err_d   = req_bad;
                    cnt_d   = 3'(MEM_LAT);
                    if (req_bad) begin
                        state_d = StResp;
                    end else if (req_store && req_size_e == SzD) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                // Counter hits zero in the cycle the memory word is valid.
                if (cnt_q == 3'd0) begin
                    if (store_q) begin
                        old_d   = mem_rdata;
                        state_d = StWrite;
                    end else begin
                        rdata_d = load_data;
                        state_d = StResp;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            old_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            store_q <= store_d;
            err_q   <= err_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_err   = (state_q == StResp) && err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_wr     = (state_q == StWrite);
    assign mem_wdata  = (state_q == StWrite) ? merge_data : '0;

endmodule
